// File: rtl/riscv_if_pkg.sv
// Shared definitions for the instruction-fetch stage: word width, NOP encoding,
// default reset PC, FSM state codes and the fetch-queue entry layout.
package riscv_if_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RV_NOP           = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [0:0] StFetch = 1'b0;
  localparam logic [0:0] StDrop  = 1'b1;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
  } fq_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/riscv_if_if.sv
// Fetch-stage bundle: imem request/response, the valid/ready hand-off to ID and
// the EX redirect. master is the fetch stage's view, slave the environment's.
interface riscv_if_if;
  import riscv_if_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;

  logic            valid;
  logic            ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc4;

  logic            redirect;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, valid, instr, pc, pc4,
    input  imem_ack, imem_rdata, ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, valid, instr, pc, pc4,
    output imem_ack, imem_rdata, ready, redirect, redirect_pc
  );

endinterface

// File: rtl/riscv_if_fetch_queue.sv
// Small FIFO of fetched {instr, pc, pc4} entries. Flush wins over push/pop; the
// head reads as a NOP with zero PCs whenever the queue is empty.
module riscv_if_fetch_queue
  import riscv_if_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  fq_entry_t                    push_data,
  input  logic                         pop,
  input  logic                         flush,
  output fq_entry_t                    head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  fq_entry_t       mem_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q;
  logic [PtrW-1:0] wr_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push;
  logic            do_pop;

  assign do_push = push && !flush && (count_q != CntW'(DEPTH));
  assign do_pop  = pop && !flush && (count_q != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CntW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CntW'(1);
    end
  end

  // Payload storage needs no reset: it is only visible while count_q != 0.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  always_comb begin
    head = '{instr: RV_NOP, pc: '0, pc4: '0};
    if (count_q != '0) head = mem_q[rd_ptr_q];
  end

  assign count = count_q;

endmodule

// File: rtl/riscv_if.sv
// Instruction-fetch stage: owns the PC, issues one-outstanding imem requests,
// queues returned words for ID and squashes in-flight responses on redirect.
module riscv_if
  import riscv_if_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned     FQ_DEPTH = 2
) (
  input logic        clk,
  input logic        rst,
  riscv_if_if.master bus
);

  localparam int unsigned CntW = $clog2(FQ_DEPTH + 1);

  logic [0:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] drop_addr_q, drop_addr_d;
  logic            started_q;

  logic            req;
  logic            push;
  logic            pop;
  logic            flush;
  fq_entry_t       push_data;
  fq_entry_t       head;
  logic [CntW-1:0] fq_count;

  // started_q keeps req low while reset is held; the first request follows release.
  assign req = started_q && ((state_q == StDrop) || (fq_count < CntW'(FQ_DEPTH)));

  assign bus.imem_req  = req;
  assign bus.imem_addr = (state_q == StDrop) ? drop_addr_q : pc_q;

  assign flush     = bus.redirect;
  assign pop       = bus.valid && bus.ready && !bus.redirect;
  assign push_data = '{instr: bus.imem_rdata, pc: pc_q, pc4: pc_q + XLEN'(4)};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    push        = 1'b0;
    case (state_q)
      StFetch: begin
        if (bus.redirect) begin
          pc_d = word_align(bus.redirect_pc);
          // An unanswered request must keep its address until the late ack arrives.
          if (req && !bus.imem_ack) begin
            state_d     = StDrop;
            drop_addr_d = pc_q;
          end
        end else if (req && bus.imem_ack) begin
          push = 1'b1;
          pc_d = pc_q + XLEN'(4);
        end
      end
      StDrop: begin
        if (bus.redirect) pc_d = word_align(bus.redirect_pc);
        if (bus.imem_ack) state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StFetch;
      pc_q        <= RESET_PC;
      drop_addr_q <= '0;
      started_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      started_q   <= 1'b1;
    end
  end

  riscv_if_fetch_queue #(
    .DEPTH(FQ_DEPTH)
  ) u_fetch_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .flush    (flush),
    .head     (head),
    .count    (fq_count)
  );

  assign bus.valid = (fq_count != '0);
  assign bus.instr = head.instr;
  assign bus.pc    = head.pc;
  assign bus.pc4   = head.pc4;

endmodule

// File: tb/tb_riscv_if.sv
// Self-checking bench for riscv_if: directed scenarios plus a randomized run
// scored against an in-order PC stream model.
`timescale 1ns/1ps
module tb_riscv_if;
  import riscv_if_pkg::*;

  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  riscv_if_if bus ();
  riscv_if_if bus2 ();

  int          mem_lat     = 0;
  int          wcnt;
  logic        ready       = 1'b1;
  logic        redirect    = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        ready2      = 1'b1;
  logic        ack;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory model: ack after mem_lat waiting cycles (0 = same cycle as req).
  assign ack = bus.imem_req && (wcnt >= mem_lat);
  always @(posedge clk or posedge rst) begin
    if (rst) wcnt <= 0;
    else if (bus.imem_req && !ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  assign bus.imem_ack    = ack;
  assign bus.imem_rdata  = rd(bus.imem_addr);
  assign bus.ready       = ready;
  assign bus.redirect    = redirect;
  assign bus.redirect_pc = redirect_pc;

  assign bus2.imem_ack    = bus2.imem_req;
  assign bus2.imem_rdata  = rd(bus2.imem_addr);
  assign bus2.ready       = ready2;
  assign bus2.redirect    = 1'b0;
  assign bus2.redirect_pc = '0;

  riscv_if #(
    .RESET_PC(32'h0000_0000),
    .FQ_DEPTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  riscv_if #(
    .RESET_PC(WRAP_PC),
    .FQ_DEPTH(4)
  ) dut_wrap (
    .clk(clk),
    .rst(rst),
    .bus(bus2.master)
  );

  task automatic do_reset();
    @(negedge clk);
    redirect = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    mem_lat = 0; ready = 1'b1; redirect = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b want=0", bus.imem_req); end
    n_checks++;
    if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", bus.valid); end
    n_checks++;
    if (bus.instr !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_instr got=%h want=00000013", bus.instr); end
    n_checks++;
    if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h want=0", bus.pc); end
    n_checks++;
    if (bus.pc4 !== 32'h0) begin n_fail++; $display("FAIL reset_pc4 got=%h want=0", bus.pc4); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL reset_first_req got=%b/%h want=1/00000000", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_zero_latency();
    logic [31:0] e;
    mem_lat = 0; ready = 1'b1;
    do_reset();
    @(negedge clk); #1;
    n_checks++;
    if ({bus.imem_req, bus.valid} !== 2'b10) begin
      n_fail++; $display("FAIL zl_first_cycle got req/valid=%b%b want=10", bus.imem_req, bus.valid);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      e = 32'(i * 4);
      n_checks++;
      if ({bus.valid, bus.pc, bus.pc4, bus.instr} !== {1'b1, e, e + 32'd4, rd(e)}) begin
        n_fail++;
        $display("FAIL zl_stream[%0d] got v=%b pc=%h pc4=%h instr=%h want v=1 pc=%h pc4=%h instr=%h",
                 i, bus.valid, bus.pc, bus.pc4, bus.instr, e, e + 32'd4, rd(e));
      end
    end
  endtask

  task automatic test_backpressure();
    int acks;
    logic [31:0] e;
    mem_lat = 0; ready = 1'b0;
    do_reset();
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); ready = 1'b0; #1;
      if (bus.imem_req && ack) acks++;
    end
    n_checks++;
    if (acks !== 2) begin n_fail++; $display("FAIL bp_fetch_count got=%0d want=2", acks); end
    n_checks++;
    if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_req_full got=%b want=0", bus.imem_req); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); ready = 1'b1; #1;
      e = 32'(i * 4);
      n_checks++;
      if ({bus.valid, bus.pc, bus.instr} !== {1'b1, e, rd(e)}) begin
        n_fail++; $display("FAIL bp_drain[%0d] got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                           i, bus.valid, bus.pc, bus.instr, e, rd(e));
      end
      if (i == 1) begin
        n_checks++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h8}) begin
          n_fail++; $display("FAIL bp_resume got=%b/%h want=1/00000008", bus.imem_req, bus.imem_addr);
        end
      end
    end
  endtask

  task automatic test_redirect_latency();
    logic found;
    logic done;
    mem_lat = 3; ready = 1'b1;
    do_reset();
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk); #1;
      if (bus.imem_req && bus.imem_addr == 32'h8) found = 1'b1;
    end
    n_checks++;
    if (found !== 1'b1) begin n_fail++; $display("FAIL rl_req8_seen got=%b want=1", found); end
    @(negedge clk); redirect = 1'b1; redirect_pc = 32'h100; #1;
    n_checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h8}) begin
      n_fail++; $display("FAIL rl_redirect_cycle got=%b/%h want=1/00000008", bus.imem_req, bus.imem_addr);
    end
    done = 1'b0;
    for (int k = 0; k < 10 && !done; k++) begin
      @(negedge clk); redirect = 1'b0; #1;
      n_checks++;
      if ({bus.imem_req, bus.imem_addr, bus.valid} !== {1'b1, 32'h8, 1'b0}) begin
        n_fail++; $display("FAIL rl_drop_hold got req=%b addr=%h valid=%b want 1/00000008/0",
                           bus.imem_req, bus.imem_addr, bus.valid);
      end
      if (ack) done = 1'b1;
    end
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL rl_drop_ack got=%b want=1", done); end
    @(negedge clk); #1;
    n_checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h100}) begin
      n_fail++; $display("FAIL rl_target_req got=%b/%h want=1/00000100", bus.imem_req, bus.imem_addr);
    end
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk); #1;
      if (bus.valid) found = 1'b1;
    end
    n_checks++;
    if ({found, bus.pc, bus.instr} !== {1'b1, 32'h100, rd(32'h100)}) begin
      n_fail++; $display("FAIL rl_first_valid got v=%b pc=%h instr=%h want v=1 pc=00000100 instr=%h",
                         found, bus.pc, bus.instr, rd(32'h100));
    end
  endtask

  task automatic test_redirect_collision(input logic [31:0] target);
    logic [31:0] t;
    t = target & 32'hFFFF_FFFC;
    mem_lat = 0; ready = 1'b1;
    do_reset();
    repeat (3) @(negedge clk);
    @(negedge clk); redirect = 1'b1; redirect_pc = target; #1;
    n_checks++;
    if ({bus.valid, bus.imem_req, ack} !== 3'b111) begin
      n_fail++; $display("FAIL rc_coincide got v/req/ack=%b%b%b want=111", bus.valid, bus.imem_req, ack);
    end
    @(negedge clk); redirect = 1'b0; #1;
    n_checks++;
    if ({bus.valid, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, t}) begin
      n_fail++; $display("FAIL rc_after got v=%b req=%b addr=%h want v=0 req=1 addr=%h",
                         bus.valid, bus.imem_req, bus.imem_addr, t);
    end
    @(negedge clk); #1;
    n_checks++;
    if ({bus.valid, bus.pc, bus.pc4, bus.instr} !== {1'b1, t, t + 32'd4, rd(t)}) begin
      n_fail++; $display("FAIL rc_target_head got v=%b pc=%h pc4=%h instr=%h want pc=%h",
                         bus.valid, bus.pc, bus.pc4, bus.instr, t);
    end
  endtask

  task automatic test_wrap();
    int acks;
    logic [31:0] e;
    ready2 = 1'b0;
    do_reset();
    acks = 0;
    @(negedge clk); #1;
    n_checks++;
    if ({bus2.imem_req, bus2.imem_addr} !== {1'b1, WRAP_PC}) begin
      n_fail++; $display("FAIL wrap_first_req got=%b/%h want=1/%h", bus2.imem_req, bus2.imem_addr, WRAP_PC);
    end
    for (int i = 0; i < 8; i++) begin
      if (bus2.imem_req) acks++;
      @(negedge clk); #1;
    end
    n_checks++;
    if ({acks, bus2.imem_req} !== {32'd4, 1'b0}) begin
      n_fail++; $display("FAIL wrap_depth4 got fetched=%0d req=%b want fetched=4 req=0", acks, bus2.imem_req);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); ready2 = 1'b1; #1;
      e = WRAP_PC + 32'(i * 4);
      n_checks++;
      if ({bus2.valid, bus2.pc, bus2.pc4, bus2.instr} !== {1'b1, e, e + 32'd4, rd(e)}) begin
        n_fail++; $display("FAIL wrap_stream[%0d] got v=%b pc=%h pc4=%h want pc=%h pc4=%h",
                           i, bus2.valid, bus2.pc, bus2.pc4, e, e + 32'd4);
      end
    end
    ready2 = 1'b1;
  endtask

  task automatic test_async_reset();
    logic found;
    mem_lat = 3; ready = 1'b0;
    do_reset();
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk); #1;
      if (bus.valid && bus.imem_req && !ack) found = 1'b1;
    end
    n_checks++;
    if (found !== 1'b1) begin n_fail++; $display("FAIL ar_midwait_seen got=%b want=1", found); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.imem_req, bus.valid, bus.instr, bus.pc} !== {1'b0, 1'b0, 32'h0000_0013, 32'h0}) begin
      n_fail++; $display("FAIL ar_immediate got req=%b v=%b instr=%h pc=%h want 0/0/00000013/0",
                         bus.imem_req, bus.valid, bus.instr, bus.pc);
    end
    @(negedge clk); rst = 1'b0; ready = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL ar_refetch got=%b/%h want=1/00000000", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] prev_addr;
    logic        prev_pending;
    int          delivered;
    mem_lat = 0; ready = 1'b1;
    do_reset();
    exp_pc = 32'h0; prev_pending = 1'b0; prev_addr = '0; delivered = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      if (cyc % 100 == 0) mem_lat = $urandom_range(0, 3);
      ready       = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = 32'($urandom_range(0, 4095));
      #1;
      if (prev_pending) begin
        n_checks++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, prev_addr}) begin
          n_fail++; $display("FAIL rnd_addr_hold cyc=%0d got=%b/%h want=1/%h",
                             cyc, bus.imem_req, bus.imem_addr, prev_addr);
        end
      end
      prev_pending = bus.imem_req && !ack;
      prev_addr    = bus.imem_addr;
      if (redirect) begin
        exp_pc = redirect_pc & 32'hFFFF_FFFC;
      end else if (bus.valid && ready) begin
        n_checks++;
        if ({bus.pc, bus.pc4, bus.instr} !== {exp_pc, exp_pc + 32'd4, rd(exp_pc)}) begin
          n_fail++; $display("FAIL rnd_stream cyc=%0d got pc=%h pc4=%h instr=%h want pc=%h pc4=%h instr=%h",
                             cyc, bus.pc, bus.pc4, bus.instr, exp_pc, exp_pc + 32'd4, rd(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
    end
    redirect = 1'b0;
    n_checks++;
    if (delivered < 200) begin n_fail++; $display("FAIL rnd_progress got=%0d want>=200", delivered); end
  endtask

  initial begin
    test_reset();
    test_zero_latency();
    test_backpressure();
    test_redirect_latency();
    test_redirect_collision(32'h0000_0200);
    test_redirect_collision(32'h0000_0206);
    test_wrap();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
